// File: rtl/riscv_pkg.sv
// Shared core package: register-file geometry and
// the state encoding of the register dump reader.
package riscv_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_AW    = $clog2(REG_COUNT);

    typedef enum logic [1:0] {
        DUMP_IDLE,
        DUMP_FETCH,
        DUMP_SEND,
        DUMP_FINISH
    } dump_state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks a register-file read port over a fixed index range and
// streams each word out on a valid/ready handshake.
module reg_dump_reader
    import riscv_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int ZERO_X0   = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic [4:0]  REG_ADDRESS,
    input  logic [31:0] REG_READ_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_DATA,
    output logic [4:0]  OUT_INDEX,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [REG_AW-1:0] FIRST_IDX = REG_AW'(FIRST_REG);
    localparam logic [REG_AW-1:0] LAST_IDX  = REG_AW'(LAST_REG);

    dump_state_e       state;
    dump_state_e       state_nxt;
    logic [REG_AW-1:0] idx;
    logic [REG_AW-1:0] idx_nxt;
    logic              capture;
    logic [31:0]       fetch_word;
    logic [31:0]       out_data_q;
    logic [REG_AW-1:0] out_index_q;

    // x0 reads as zero architecturally even if the array holds junk
    assign fetch_word = (ZERO_X0 != 0 && idx == '0) ? '0 : REG_READ_DATA;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= DUMP_IDLE;
            idx         <= FIRST_IDX;
            out_data_q  <= '0;
            out_index_q <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (capture) begin
                out_data_q  <= fetch_word;
                out_index_q <= idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        capture   = 1'b0;
        unique case (state)
            DUMP_IDLE: begin
                if (START) begin
                    state_nxt = DUMP_FETCH;
                    idx_nxt   = FIRST_IDX;
                end
            end
            DUMP_FETCH: begin
                capture   = 1'b1;
                state_nxt = DUMP_SEND;
            end
            DUMP_SEND: begin
                if (OUT_READY) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DUMP_FINISH;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = DUMP_FETCH;
                    end
                end
            end
            DUMP_FINISH: begin
                state_nxt = DUMP_IDLE;
            end
        endcase
    end

    assign REG_ADDRESS = (state == DUMP_IDLE) ? FIRST_IDX : idx;
    assign OUT_VALID   = (state == DUMP_SEND);
    assign BUSY        = (state != DUMP_IDLE);
    assign DONE        = (state == DUMP_FINISH);
    assign OUT_DATA    = out_data_q;
    assign OUT_INDEX   = out_index_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized bench for reg_dump_reader: three configurations share
// stimulus and a register array, checked against a transfer-level model.
module tb_reg_dump_reader;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        START;
    logic        RDY;
    logic [31:0] mem [32];

    logic [4:0]  ra [3];
    logic [31:0] rd [3];
    logic        ov [3];
    logic [31:0] od [3];
    logic [4:0]  oi [3];
    logic        bz [3];
    logic        dn [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        reg_dump_reader #(
            .FIRST_REG(g == 2 ? 9 : 0),
            .LAST_REG (g == 2 ? 9 : 31),
            .ZERO_X0  (g == 1 ? 0 : 1)
        ) u_dut (
            .CLK          (CLK),
            .RST          (RST),
            .START        (START),
            .REG_ADDRESS  (ra[g]),
            .REG_READ_DATA(rd[g]),
            .OUT_VALID    (ov[g]),
            .OUT_READY    (RDY),
            .OUT_DATA     (od[g]),
            .OUT_INDEX    (oi[g]),
            .BUSY         (bz[g]),
            .DONE         (dn[g])
        );
        assign rd[g] = mem[ra[g]];
    end

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic int fr(int k);
        return (k == 2) ? 9 : 0;
    endfunction
    function automatic int lr(int k);
        return (k == 2) ? 9 : 31;
    endfunction
    function automatic bit zx(int k);
        return k != 1;
    endfunction

    // Model: a dump is a list of words FIRST..LAST; each word appears
    // one cycle after it is fetched, and is fetched one cycle after the
    // previous word was taken (or after START was taken).
    bit          mb [3];
    bit          mp [3];
    bit          mv [3];
    bit          md [3];
    int          mc [3];
    logic [31:0] mdat [3];
    int          midx [3];
    int          words [3];
    int          dones [3];
    int          xf [3][32];
    logic [31:0] got [3][32];
    int          e = 0;
    int          acc0 = -1;

    always @(posedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            if (RST) begin
                mb[k] = 0; mp[k] = 0; mv[k] = 0; md[k] = 0;
                mdat[k] = 0; midx[k] = 0; mc[k] = fr(k);
            end else if (md[k]) begin
                md[k] = 0;
                mb[k] = 0;
            end else if (!mb[k]) begin
                if (START) begin
                    mb[k] = 1;
                    mc[k] = fr(k);
                    mp[k] = 1;
                    if (k == 0) acc0 = e;
                end
            end else if (mp[k]) begin
                mdat[k] = (zx(k) && mc[k] == 0) ? 32'h0 : mem[mc[k]];
                midx[k] = mc[k];
                mv[k] = 1;
                mp[k] = 0;
            end else if (mv[k] && RDY) begin
                words[k]++;
                got[k][mc[k]] = mdat[k];
                xf[k][mc[k]]++;
                mv[k] = 0;
                if (mc[k] == lr(k)) begin
                    md[k] = 1;
                    dones[k]++;
                end else begin
                    mc[k]++;
                    mp[k] = 1;
                end
            end
        end
        e++;
    end

    int done_off = 0;
    int fv_off   = 0;
    int fv_acc   = -1;

    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("valid%0d", k), 32'(ov[k]), 32'(mv[k]));
            chk($sformatf("busy%0d", k), 32'(bz[k]), 32'(mb[k]));
            chk($sformatf("done%0d", k), 32'(dn[k]), 32'(md[k]));
            chk($sformatf("data%0d", k), od[k], mdat[k]);
            chk($sformatf("index%0d", k), 32'(oi[k]), 32'(midx[k]));
            chk($sformatf("addr%0d", k), 32'(ra[k]),
                32'(mb[k] ? mc[k] : fr(k)));
        end
        if (dn[0]) done_off = e - acc0;
        if (ov[0] && acc0 != fv_acc) begin
            fv_off = e - acc0;
            fv_acc = acc0;
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, input string nm);
        int n = 0;
        while (!dn[k] && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, 32'(dn[k]), 32'd1);
    endtask

    int w0, d0, w2, d2, n, stall, dup;
    int xb [32];
    bit pulsed;

    initial begin
        RST = 1'b1;
        START = 1'b0;
        RDY = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0] = 32'hDEAD;
        mem[5] = 32'h6;
        mem[9] = 32'h2004;
        repeat (3) tick();
        chk("rst_valid", 32'(ov[0]), 32'd0);
        chk("rst_busy", 32'(bz[0]), 32'd0);
        chk("rst_done", 32'(dn[0]), 32'd0);
        chk("rst_data", od[0], 32'd0);
        chk("rst_index", 32'(oi[0]), 32'd0);
        chk("rst_addr2", 32'(ra[2]), 32'd9);
        RST = 1'b0;
        tick();

        // full dump at full rate
        w0 = words[0]; d0 = dones[0]; w2 = words[2];
        pulse_start();
        wait_done(0, 200, "full");
        chk("full_words", 32'(words[0] - w0), 32'd32);
        chk("full_dones", 32'(dones[0] - d0), 32'd1);
        chk("x5", got[0][5], 32'h6);
        chk("x9", got[0][9], 32'h2004);
        chk("x0_zeroed", got[0][0], 32'h0);
        chk("x0_raw", got[1][0], 32'hDEAD);
        chk("done_cycle", 32'(done_off), 32'd65);
        chk("first_valid", 32'(fv_off), 32'd2);
        chk("single_words", 32'(words[2] - w2), 32'd1);
        chk("single_x9", got[2][9], 32'h2004);
        repeat (2) tick();

        // consumer stall on index 9
        w0 = words[0];
        for (int i = 0; i < 32; i++) xb[i] = xf[0][i];
        pulse_start();
        stall = 0;
        n = 0;
        while (!dn[0] && n < 300) begin
            if (ov[0] && oi[0] == 5'd9 && stall < 5) begin
                RDY = 1'b0;
                stall++;
                chk("stall_valid", 32'(ov[0]), 32'd1);
                chk("stall_data", od[0], 32'h2004);
            end else begin
                RDY = 1'b1;
            end
            tick();
            n++;
        end
        RDY = 1'b1;
        chk("stall_timeout", 32'(dn[0]), 32'd1);
        chk("stall_cycles", 32'(stall), 32'd5);
        chk("stall_x9_once", 32'(xf[0][9] - xb[9]), 32'd1);
        chk("stall_words", 32'(words[0] - w0), 32'd32);
        repeat (2) tick();

        // START while sending index 3 is ignored
        w0 = words[0]; d0 = dones[0];
        for (int i = 0; i < 32; i++) xb[i] = xf[0][i];
        pulse_start();
        pulsed = 0;
        n = 0;
        while (!dn[0] && n < 300) begin
            START = (ov[0] && oi[0] == 5'd3 && !pulsed);
            if (START) pulsed = 1;
            tick();
            n++;
        end
        START = 1'b0;
        chk("restart_timeout", 32'(dn[0]), 32'd1);
        chk("restart_pulsed", 32'(pulsed), 32'd1);
        tick();
        dup = 0;
        for (int i = 0; i < 32; i++) if (xf[0][i] - xb[i] != 1) dup++;
        chk("restart_dups", 32'(dup), 32'd0);
        chk("restart_words", 32'(words[0] - w0), 32'd32);
        chk("restart_dones", 32'(dones[0] - d0), 32'd1);
        repeat (2) tick();

        // reset while index 7 is on offer
        d0 = dones[0];
        pulse_start();
        n = 0;
        while (!(ov[0] && oi[0] == 5'd7) && n < 100) begin
            tick();
            n++;
        end
        chk("abort_reach7", 32'(ov[0] && oi[0] == 5'd7), 32'd1);
        RST = 1'b1;
        START = 1'b1;
        tick();
        RST = 1'b0;
        START = 1'b0;
        chk("abort_valid", 32'(ov[0]), 32'd0);
        chk("abort_busy", 32'(bz[0]), 32'd0);
        repeat (3) tick();
        chk("abort_nodone", 32'(dones[0] - d0), 32'd0);
        pulse_start();
        n = 0;
        while (!ov[0] && n < 10) begin
            tick();
            n++;
        end
        chk("abort_resend_valid", 32'(ov[0]), 32'd1);
        chk("abort_resend_index", 32'(oi[0]), 32'd0);
        wait_done(0, 200, "abort_resend");
        repeat (2) tick();

        // single-register range, back-to-back dumps
        w2 = words[2]; d2 = dones[2];
        pulse_start();
        wait_done(2, 20, "single1");
        tick();
        pulse_start();
        wait_done(2, 20, "single2");
        chk("single_dones", 32'(dones[2] - d2), 32'd2);
        chk("single_words2", 32'(words[2] - w2), 32'd2);
        wait_done(0, 200, "single_bg");
        repeat (2) tick();

        // random traffic, register writes mid-dump, sporadic resets
        for (int c = 0; c < 3000; c++) begin
            RDY   = ($urandom % 4) != 0;
            START = ($urandom % 8) == 0;
            RST   = ($urandom % 200) == 0;
            if (($urandom % 3) == 0) mem[$urandom % 32] = $urandom;
            tick();
        end
        RST = 1'b0;
        START = 1'b0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter FIRST_REG, default 0: first register index dumped.
REQ-002 SHALL have parameter LAST_REG, default 31: last register index dumped; FIRST_REG <= LAST_REG <= 31.
REQ-003 SHALL have parameter ZERO_X0, default 1: when 1, the word sent for index 0 is forced to 32'h0.
REQ-004 SHALL have port CLK, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port START, input, 1 bit: dump request, sampled only in IDLE.
REQ-007 SHALL have port REG_ADDRESS, output, 5 bits: register-file read port address.
REQ-008 SHALL have port REG_READ_DATA, input, 32 bits: combinational read data for REG_ADDRESS.
REQ-009 SHALL have port OUT_VALID, output, 1 bit: OUT_DATA/OUT_INDEX hold a word.
REQ-010 SHALL have port OUT_READY, input, 1 bit: consumer accepts the word this cycle.
REQ-011 SHALL have port OUT_DATA, output, 32 bits: register contents.
REQ-012 SHALL have port OUT_INDEX, output, 5 bits: register index of OUT_DATA.
REQ-013 SHALL have port BUSY, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port DONE, output, 1 bit: single-cycle pulse after the last word is accepted.

Function
REQ-015 SHALL implement a state machine with states IDLE, FETCH, SEND, FINISH.
REQ-016 In IDLE with START=1, the next state SHALL be FETCH, and the index counter SHALL load FIRST_REG.
REQ-017 In IDLE, REG_ADDRESS SHALL equal FIRST_REG; in all other states it SHALL equal the index counter.
REQ-018 In FETCH, REG_READ_DATA SHALL be captured into OUT_DATA (or 0 per REQ-003), the index SHALL be copied to OUT_INDEX, and the next state SHALL be SEND.
REQ-019 OUT_VALID SHALL be 1 exactly while in SEND.
REQ-020 In SEND, OUT_DATA and OUT_INDEX SHALL stay stable while OUT_READY=0; OUT_VALID SHALL not drop without a transfer.
REQ-021 In SEND with OUT_READY=1 and index != LAST_REG, the index SHALL increment by 1 and the next state SHALL be FETCH.
REQ-022 In SEND with OUT_READY=1 and index == LAST_REG, the next state SHALL be FINISH; no wrap past LAST_REG.
REQ-023 In FINISH, DONE SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-024 START SHALL be ignored in FETCH, SEND and FINISH; START in the IDLE cycle following FINISH SHALL begin a new dump.
REQ-025 Latency SHALL be: START accepted in cycle n, first OUT_VALID in cycle n+2; each subsequent word 2 cycles after the prior acceptance; peak throughput 1 word per 2 cycles.
REQ-026 If FIRST_REG == LAST_REG, exactly one word SHALL be sent, followed by DONE.
REQ-027 Register-file writes during a dump SHALL be visible for any index not yet fetched; no snapshot is taken.

Reset
REQ-028 RST=1 at a clock edge SHALL force state IDLE, OUT_VALID=0, DONE=0, BUSY=0, OUT_DATA=0, OUT_INDEX=0, and index counter = FIRST_REG, regardless of state.
REQ-029 RST asserted mid-dump SHALL abandon the dump with no DONE; the next dump SHALL restart at FIRST_REG.
REQ-030 RST SHALL take priority over START and OUT_READY in the same cycle.

Structure
REQ-031 The state encoding and the constant REG_COUNT=32 SHALL live in the shared riscv_pkg package.
REQ-032 The block SHALL be a single module with no sub-module; it connects to one read port of register_file.

Verification
REQ-033 Preload x5=6 and x9=32'h2004, FIRST_REG=0, LAST_REG=31, OUT_READY=1: 32 words, index 5 -> 6, index 9 -> 32'h2004, DONE once at cycle 65 after START.
REQ-034 Preload x0=32'hDEAD, ZERO_X0=1: the word for index 0 SHALL be 0; with ZERO_X0=0, it SHALL be 32'hDEAD.
REQ-035 Hold OUT_READY=0 for 5 cycles on index 9: OUT_VALID=1 and OUT_DATA=32'h2004 stable throughout; one transfer on release.
REQ-036 Pulse START during SEND of index 3: no restart, no duplicate words, single DONE.
REQ-037 Assert RST while OUT_VALID=1 at index 7: next cycle OUT_VALID=0, BUSY=0; the following START resends from index 0.
REQ-038 FIRST_REG=LAST_REG=9: single word 32'h2004, index 9, then DONE; START in the cycle after DONE begins a second dump.
